// File: rtl/bcd_operand_loader.sv
// Captures a BCD operand pair plus carry-in from switches on a debounced key press
// and offers it to a downstream digit adder through a valid/ready handshake.
module bcd_operand_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [8:0] SW,
  input  logic       KEY_LOAD,
  input  logic       out_ready,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       CIN,
  output logic       out_valid,
  output logic       ERR,
  output logic       OVERRUN
);

  localparam logic [0:0]  IDLE     = 1'b0;
  localparam logic [0:0]  HOLD     = 1'b1;
  localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);

  logic        s1;
  logic        s2;
  logic        db;
  logic [19:0] cnt;
  logic [0:0]  state;

  logic press;
  logic digits_ok;
  logic take;

  // Press fires on the same edge that db falls, so the FSM reacts without an extra cycle.
  assign press     = db && !s2 && (cnt == CNT_LAST);
  assign digits_ok = (SW[3:0] <= 4'd9) && (SW[7:4] <= 4'd9);

  // Handshake: a set transfers on any edge where out_valid && out_ready; out_valid
  // never drops without a transfer and A/B/CIN never change while it is high unless
  // a transfer happens on the same edge. A press coinciding with a transfer is taken.
  assign take      = press && ((state == IDLE) || out_ready);
  assign out_valid = (state == HOLD);

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      s1  <= 1'b1;
      s2  <= 1'b1;
      db  <= 1'b1;
      cnt <= '0;
    end else begin
      s1 <= KEY_LOAD;
      s2 <= s1;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state   <= IDLE;
      A       <= 4'd0;
      B       <= 4'd0;
      CIN     <= 1'b0;
      ERR     <= 1'b0;
      OVERRUN <= 1'b0;
    end else if (take) begin
      if (digits_ok) begin
        A     <= SW[3:0];
        B     <= SW[7:4];
        CIN   <= SW[8];
        ERR   <= 1'b0;
        state <= HOLD;
      end else begin
        ERR   <= 1'b1;
        state <= IDLE;
      end
    end else if (press) begin
      // Only reachable in HOLD without out_ready: the press is dropped.
      OVERRUN <= 1'b1;
    end else if ((state == HOLD) && out_ready) begin
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_bcd_operand_loader.sv
// Directed bench for bcd_operand_loader with a short debounce window; captured
// operand sets are predicted into a queue and compared when the DUT presents them.
module tb_bcd_operand_loader;

  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic [8:0] sw;
  logic       key;
  logic       rdy;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       valid;
  logic       err;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q[$];
  logic [8:0] last_ops = 9'h000;

  bcd_operand_loader #(.DEBOUNCE_CYCLES(D)) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .SW       (sw),
    .KEY_LOAD (key),
    .out_ready(rdy),
    .A        (a),
    .B        (b),
    .CIN      (cin),
    .out_valid(valid),
    .ERR      (err),
    .OVERRUN  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_new_ops(input string tag);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s observed=%0h expected=<empty queue>", tag, {cin, b, a});
    end else begin
      last_ops = exp_q.pop_front();
      chk(tag, {23'd0, cin, b, a}, {23'd0, last_ops});
    end
  endtask

  task automatic chk_held_ops(input string tag);
    chk(tag, {23'd0, cin, b, a}, {23'd0, last_ops});
  endtask

  // Hold key low until the edge where the press registers (edge D+2).
  task automatic press_key(input logic [8:0] val, input logic push);
    sw  = val;
    key = 1'b0;
    if (push) exp_q.push_back(val);
    repeat (D + 2) tick();
  endtask

  task automatic release_key();
    key = 1'b1;
    repeat (D + 3) tick();
  endtask

  initial begin
    rst = 1'b1;
    sw  = 9'h000;
    key = 1'b1;
    rdy = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_ops", {23'd0, cin, b, a}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_db", {31'd0, dut.db}, 32'd1);

    // Basic latency: valid appears after edge D+2, not before.
    sw  = 9'h137;
    key = 1'b0;
    exp_q.push_back(9'h137);
    repeat (D + 1) tick();
    chk("lat_early_valid", {31'd0, valid}, 32'd0);
    tick();
    chk("lat_valid", {31'd0, valid}, 32'd1);
    chk_new_ops("lat_ops");
    chk("lat_err", {31'd0, err}, 32'd0);
    release_key();
    chk("release_no_event", {31'd0, valid}, 32'd1);
    sw  = 9'h0ff;
    tick();
    chk_held_ops("hold_sw_ignored");
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    chk("xfer_valid", {31'd0, valid}, 32'd0);
    chk_held_ops("xfer_ops_kept");

    // Short glitches never confirm a level.
    sw  = 9'h011;
    key = 1'b0; repeat (3) tick();
    key = 1'b1; repeat (3) tick();
    key = 1'b0; repeat (2) tick();
    key = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("glitch_valid", {31'd0, valid}, 32'd0);
      chk("glitch_db", {31'd0, dut.db}, 32'd1);
    end

    // Non-BCD digit flags ERR and leaves the operands alone.
    press_key(9'h00c, 1'b0);
    chk("bad_err", {31'd0, err}, 32'd1);
    chk("bad_valid", {31'd0, valid}, 32'd0);
    chk_held_ops("bad_ops_kept");
    release_key();
    press_key(9'h0a5, 1'b0);
    chk("bad_hi_err", {31'd0, err}, 32'd1);
    release_key();
    press_key(9'h045, 1'b1);
    chk("good_err_clr", {31'd0, err}, 32'd0);
    chk("good_valid", {31'd0, valid}, 32'd1);
    chk_new_ops("good_ops");
    release_key();

    // Press while pending and not ready is dropped and sets OVERRUN.
    press_key(9'h198, 1'b0);
    chk_held_ops("ovr_ops_kept");
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    chk("ovr_valid", {31'd0, valid}, 32'd1);
    chk("ovr_err", {31'd0, err}, 32'd0);
    release_key();
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    chk("ovr_xfer_valid", {31'd0, valid}, 32'd0);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);

    // Press landing on the transfer edge reloads without a gap in valid.
    press_key(9'h026, 1'b1);
    chk_new_ops("b2b_first_ops");
    release_key();
    sw  = 9'h189;
    key = 1'b0;
    exp_q.push_back(9'h189);
    repeat (D + 1) tick();
    chk("b2b_pre_valid", {31'd0, valid}, 32'd1);
    chk_held_ops("b2b_pre_ops");
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    chk("b2b_valid", {31'd0, valid}, 32'd1);
    chk_new_ops("b2b_new_ops");
    chk("b2b_overrun_kept", {31'd0, overrun}, 32'd1);
    release_key();

    // Reset during HOLD and an in-progress debounce, key kept low afterwards.
    sw  = 9'h052;
    key = 1'b0;
    repeat (D) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_ops = 9'h000;
    chk_held_ops("mid_rst_ops");
    chk("mid_rst_valid", {31'd0, valid}, 32'd0);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    chk("mid_rst_overrun", {31'd0, overrun}, 32'd0);
    exp_q.push_back(9'h052);
    repeat (D + 1) tick();
    chk("post_rst_early", {31'd0, valid}, 32'd0);
    tick();
    chk("post_rst_valid", {31'd0, valid}, 32'd1);
    chk_new_ops("post_rst_ops");
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    for (int i = 0; i < 2 * D; i++) begin
      tick();
      chk("single_press", {31'd0, valid}, 32'd0);
    end
    key = 1'b1;
    repeat (D + 3) tick();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_operand_loader.md
BCD_OPERAND_LOADER -- requirements
Module: bcd_operand_loader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz), is the number of consecutive stable cycles that confirm a key level; legal range 1..2^20-1.
REQ-002 CLOCK_50  input  1  the single clock; all state changes on its rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 SW  input  9  raw operand switches: SW[3:0] = digit A, SW[7:4] = digit B, SW[8] = carry-in.
REQ-005 KEY_LOAD  input  1  raw active-low pushbutton, asynchronous to CLOCK_50, may bounce.
REQ-006 out_ready  input  1  the downstream BCD digit adder accepts the operand set.
REQ-007 A  output  4  captured BCD digit A.
REQ-008 B  output  4  captured BCD digit B.
REQ-009 CIN  output  1  captured carry-in.
REQ-010 out_valid  output  1  A/B/CIN hold a valid, not-yet-consumed operand set.
REQ-011 ERR  output  1  the last press captured a non-BCD digit.
REQ-012 OVERRUN  output  1  sticky flag: a press was dropped while an operand set was pending.

Function
REQ-013 KEY_LOAD shall pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-014 Debouncer: register db holds the confirmed key level; counter cnt clears to 0 on any edge where s2 == db, else increments; on the edge where the increment reaches DEBOUNCE_CYCLES, db takes s2 and cnt clears.
REQ-015 Press event = db transition 1->0 only; db 0->1 (release) shall produce no event.
REQ-016 A low level lasting fewer than DEBOUNCE_CYCLES synchronized cycles shall produce no event and shall leave db unchanged.
REQ-017 Latency: with KEY_LOAD held low from edge 1, out_valid shall be high after edge DEBOUNCE_CYCLES+2 (registered on the edge where db falls).
REQ-018 States: IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-019 IDLE + event + SW[3:0]<=9 + SW[7:4]<=9: capture A, B, CIN from SW on that edge, clear ERR, go to HOLD.
REQ-020 IDLE + event + either digit >9 (10..15): keep A/B/CIN unchanged, set ERR=1, stay in IDLE.
REQ-021 HOLD: A/B/CIN shall stay constant regardless of SW activity until a transfer occurs.
REQ-022 Transfer = out_valid && out_ready on an edge; without a simultaneous event, go to IDLE (out_valid=0 next cycle); A/B/CIN keep their values.
REQ-023 Transfer and event on the same edge: the event shall be processed as in IDLE (REQ-019/020); with valid digits out_valid stays 1 with new values.
REQ-024 HOLD + event without out_ready: event dropped, OVERRUN set to 1, ERR and outputs unchanged, SW not checked.
REQ-025 OVERRUN shall clear only on RESET.
REQ-026 Output signals shall come directly from registers, with no combinational path from SW, KEY_LOAD or out_ready to any output.

Reset
REQ-027 On a RESET edge: A=0, B=0, CIN=0, out_valid=0, ERR=0, OVERRUN=0, state=IDLE, s1=s2=db=1 (released), cnt=0.
REQ-028 RESET has priority over every event or transfer on the same edge; any in-progress debounce count shall be discarded.
REQ-029 If KEY_LOAD is held low through and after RESET, exactly one press shall be detected DEBOUNCE_CYCLES+2 edges after the first non-reset edge.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 SW=9'h1_37, KEY_LOAD low from edge 1, out_ready=0 -> out_valid=1 after edge 6 with A=7, B=3, CIN=1, ERR=0.
REQ-031 KEY_LOAD low for 3 cycles, high for 3, low for 2, then high -> out_valid stays 0 and db stays 1.
REQ-032 SW[3:0]=4'hC at press -> ERR=1, out_valid=0; next press with SW=9'h0_45 -> A=5, B=4, ERR=0, out_valid=1.
REQ-033 HOLD with out_ready=0, second press with different SW -> outputs unchanged, OVERRUN=1; out_ready=1 for one cycle -> out_valid=0 next cycle, OVERRUN stays 1.
REQ-034 Debounced press lands on the same edge as out_ready=1 in HOLD -> new operands captured, out_valid remains 1 without a gap.
REQ-035 RESET asserted mid-HOLD and mid-debounce -> all outputs 0 next cycle; KEY_LOAD still low -> out_valid high 6 edges after RESET deasserts.
